exe_result_fifo: RTL and testbench

EXE_RESULT_FIFO -- requirements
Module: exe_result_fifo

---
 rtl/exe_result_fifo.sv | 185 ++++++++++++++++++
 tb/tb_exe_result_fifo.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_result_fifo.sv
// -----------------------------------------------------------------------------
// exe_result_fifo
//   First-word-fall-through FIFO that buffers execution-unit results
//   (operation code, result word, {OF,BF,PF,VF} flags) between an execution
//   unit and its consumer, with valid/ready handshakes on both sides.
//
//   Extras:
//     - o_count / o_full / o_empty occupancy indicators
//     - o_drops : saturating count of offers rejected while full
//     - o_sticky: accumulated flags of accepted pushes, present only when the
//                 macro EXE_FIFO_STICKY_EN is defined (otherwise tied to 0 and
//                 i_clr_sticky is ignored)
//
//   DEPTH must be a power of two and at least 2 so the pointers wrap for free.
// -----------------------------------------------------------------------------
module exe_result_fifo #(
  parameter int N     = 4,   // operation code width
  parameter int BITS  = 8,   // result width
  parameter int DEPTH = 4    // number of entries (power of two, >= 2)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  // upstream (execution unit) side
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [N-1:0]             i_oper,
  input  logic [BITS-1:0]          i_result,
  input  logic [3:0]               i_flags,
  // downstream side
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [N-1:0]             o_oper,
  output logic [BITS-1:0]          o_result,
  output logic [3:0]               o_flags,
  // status
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [7:0]               o_drops,
  input  logic                     i_clr_sticky,
  output logic [3:0]               o_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [N-1:0]    oper;
    logic [BITS-1:0] result;
    logic [3:0]      flags;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_drops;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  entry_t w_in_entry;
  entry_t w_head;
  logic   w_full;
  logic   w_empty;
  logic   w_push;
  logic   w_pop;

  assign w_in_entry = '{oper: i_oper, result: i_result, flags: i_flags};

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Acceptance depends only on the registered occupancy, so a pop in the same
  // cycle never frees a slot for the push: no path from i_ready to o_ready.
  assign w_push = i_valid && !w_full;
  assign w_pop  = i_ready && !w_empty;

  // ---------------------------------------------------------------------------
  // Storage write: entry lands at the write pointer on every accepted push
  // ---------------------------------------------------------------------------
  // NOTE: the entry array carries no reset; occupancy is tracked by r_count and
  // the head outputs are masked while empty, so stale contents are never seen.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer: advances on push, wraps modulo DEPTH naturally
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Read pointer: advances on pop, wraps modulo DEPTH naturally
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy: +1 on push only, -1 on pop only, unchanged on both or neither
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drop counter: counts offers turned away while full, saturating at 255
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drops <= '0;
    end else if (i_valid && w_full && (r_drops != 8'hFF)) begin
      r_drops <= r_drops + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags (optional)
  // ---------------------------------------------------------------------------
`ifdef EXE_FIFO_STICKY_EN
  logic [3:0] r_sticky;

  // Accumulate flags of accepted pushes; a clear in the same cycle as a push
  // restarts the accumulation from that push's flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sticky <= '0;
    end else if (i_clr_sticky) begin
      r_sticky <= w_push ? i_flags : 4'h0;
    end else if (w_push) begin
      r_sticky <= r_sticky | i_flags;
    end
  end

  assign o_sticky = r_sticky;
`else
  // Feature absent: the clear input is deliberately left without effect.
  logic w_unused_clr_sticky;
  assign w_unused_clr_sticky = i_clr_sticky;
  assign o_sticky            = 4'h0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: head entry falls through, zeroed while empty
  // ---------------------------------------------------------------------------
  assign w_head   = r_mem[r_rd_ptr];

  assign o_oper   = w_empty ? '0 : w_head.oper;
  assign o_result = w_empty ? '0 : w_head.result;
  assign o_flags  = w_empty ? '0 : w_head.flags;

  assign o_valid  = !w_empty;
  assign o_ready  = !w_full;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_count  = r_count;
  assign o_drops  = r_drops;

endmodule

// File: tb/tb_exe_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_exe_result_fifo
//   Self-checking bench for exe_result_fifo (N=4, BITS=8, DEPTH=4).
//   A queue-based model tracks the FIFO contents, drop count and sticky flags;
//   scenario tasks drive stimulus and compare the DUT against it inline.
//   Build with +define+EXE_FIFO_STICKY_EN to exercise the sticky flags.
// -----------------------------------------------------------------------------
module tb_exe_result_fifo;

  localparam int N     = 4;
  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            i_clk;
  logic            i_rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [N-1:0]    i_oper;
  logic [BITS-1:0] i_result;
  logic [3:0]      i_flags;
  logic            o_valid;
  logic            i_ready;
  logic [N-1:0]    o_oper;
  logic [BITS-1:0] o_result;
  logic [3:0]      o_flags;
  logic [CW-1:0]   o_count;
  logic            o_full;
  logic            o_empty;
  logic [7:0]      o_drops;
  logic            i_clr_sticky;
  logic [3:0]      o_sticky;

  exe_result_fifo #(.N(N), .BITS(BITS), .DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_oper       (i_oper),
    .i_result     (i_result),
    .i_flags      (i_flags),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_oper       (o_oper),
    .o_result     (o_result),
    .o_flags      (o_flags),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_drops      (o_drops),
    .i_clr_sticky (i_clr_sticky),
    .o_sticky     (o_sticky)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0]    oper;
    logic [BITS-1:0] result;
    logic [3:0]      flags;
  } ent_t;

  ent_t       q[$];
  int         m_drops;
  logic [3:0] m_sticky;
  int         n_checks;
  int         n_errors;

  function automatic void model_reset();
    q.delete();
    m_drops  = 0;
    m_sticky = 4'h0;
  endfunction

  // Apply the current inputs across one rising edge, to DUT and model alike.
  task automatic step();
    bit   push;
    bit   pop;
    ent_t e;
    push     = i_valid && (q.size() < DEPTH);
    pop      = i_ready && (q.size() > 0);
    e.oper   = i_oper;
    e.result = i_result;
    e.flags  = i_flags;
    if (i_valid && !push && m_drops < 255) m_drops++;
`ifdef EXE_FIFO_STICKY_EN
    if (i_clr_sticky) m_sticky = push ? i_flags : 4'h0;
    else if (push)    m_sticky = m_sticky | i_flags;
`endif
    @(posedge i_clk);
    #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
  endtask

  task automatic rand_entry();
    i_oper   = N'($urandom);
    i_result = BITS'($urandom);
    i_flags  = 4'($urandom);
  endtask

  // Empty the FIFO (bounded) so each scenario starts from a known state.
  task automatic drain();
    i_valid      = 1'b0;
    i_ready      = 1'b1;
    i_clr_sticky = 1'b0;
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) step();
    i_ready = 1'b0;
    n_checks++;
    if (o_empty !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_empty: got %0b expected 1", o_empty);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_clr_sticky = 1'b0;
    i_oper = '0; i_result = '0; i_flags = '0;
    model_reset();
    #2;
    n_checks += 9;
    if (o_count  !== '0)   begin n_errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    if (o_empty  !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %0b expected 1", o_empty); end
    if (o_full   !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %0b expected 0", o_full); end
    if (o_valid  !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
    if (o_ready  !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %0b expected 1", o_ready); end
    if (o_result !== '0)   begin n_errors++; $display("FAIL reset_result: got %0h expected 0", o_result); end
    if (o_oper !== '0 || o_flags !== '0) begin n_errors++; $display("FAIL reset_head: got oper %0h flags %0h expected 0", o_oper, o_flags); end
    if (o_drops  !== 8'd0) begin n_errors++; $display("FAIL reset_drops: got %0d expected 0", o_drops); end
    if (o_sticky !== 4'h0) begin n_errors++; $display("FAIL reset_sticky: got %0h expected 0", o_sticky); end
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
  endtask

  task automatic test_sticky();
    logic [3:0] flg [3];
    logic [3:0] exp [3];
    flg[0] = 4'b1000; flg[1] = 4'b0010; flg[2] = 4'b0100;
`ifdef EXE_FIFO_STICKY_EN
    exp[0] = 4'b1000; exp[1] = 4'b1010; exp[2] = 4'b0100;
`else
    exp[0] = 4'b0000; exp[1] = 4'b0000; exp[2] = 4'b0000;
`endif
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_entry();
      i_valid      = 1'b1;
      i_flags      = flg[i];
      i_clr_sticky = (i == 2);
      step();
      n_checks += 2;
      if (o_sticky !== exp[i])   begin n_errors++; $display("FAIL sticky_seq%0d: got %04b expected %04b", i, o_sticky, exp[i]); end
      if (o_sticky !== m_sticky) begin n_errors++; $display("FAIL sticky_model%0d: got %04b expected %04b", i, o_sticky, m_sticky); end
    end
    // Clear with no push.
    i_valid = 1'b0; i_clr_sticky = 1'b1;
    step();
    i_clr_sticky = 1'b0;
    n_checks++;
    if (o_sticky !== m_sticky) begin n_errors++; $display("FAIL sticky_clear: got %04b expected %04b", o_sticky, m_sticky); end
    drain();
  endtask

  task automatic test_single_push();
    drain();
    i_valid = 1'b1; i_oper = 4'h0; i_result = 8'h12; i_flags = 4'b0001;
    step();
    i_valid = 1'b0;
    n_checks += 4;
    if (o_valid  !== 1'b1)    begin n_errors++; $display("FAIL single_valid: got %0b expected 1", o_valid); end
    if (o_result !== 8'h12)   begin n_errors++; $display("FAIL single_result: got %0h expected 12", o_result); end
    if (o_flags  !== 4'b0001) begin n_errors++; $display("FAIL single_flags: got %04b expected 0001", o_flags); end
    if (o_count  !== CW'(1))  begin n_errors++; $display("FAIL single_count: got %0d expected 1", o_count); end
    i_ready = 1'b1;
    step();
    n_checks += 2;
    if (o_empty  !== 1'b1) begin n_errors++; $display("FAIL single_pop_empty: got %0b expected 1", o_empty); end
    if (o_result !== '0)   begin n_errors++; $display("FAIL single_pop_zero: got %0h expected 0", o_result); end
    i_ready = 1'b0;
  endtask

  task automatic test_fill_drop();
    drain();
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_entry();
      i_valid = 1'b1;
      step();
      n_checks += 3;
      if (o_count !== CW'(q.size()))     begin n_errors++; $display("FAIL fill_count%0d: got %0d expected %0d", i, o_count, q.size()); end
      if (o_full  !== (q.size() == DEPTH)) begin n_errors++; $display("FAIL fill_full%0d: got %0b expected %0b", i, o_full, q.size() == DEPTH); end
      if (o_drops !== 8'(m_drops))       begin n_errors++; $display("FAIL fill_drops%0d: got %0d expected %0d", i, o_drops, m_drops); end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (o_result !== q[0].result || o_oper !== q[0].oper || o_flags !== q[0].flags) begin
        n_errors++;
        $display("FAIL fill_pop%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", i,
                 o_oper, o_result, o_flags, q[0].oper, q[0].result, q[0].flags);
      end
      step();
    end
    n_checks++;
    if (o_empty !== 1'b1) begin n_errors++; $display("FAIL fill_drained: got %0b expected 1", o_empty); end
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    drain();
    i_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin rand_entry(); i_valid = 1'b1; step(); end
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (o_result !== q[0].result || o_flags !== q[0].flags) begin
        n_errors++;
        $display("FAIL b2b_head%0d: got %0h/%0h expected %0h/%0h", i, o_result, o_flags, q[0].result, q[0].flags);
      end
      rand_entry();
      step();
      n_checks++;
      if (o_count !== CW'(2)) begin n_errors++; $display("FAIL b2b_count%0d: got %0d expected 2", i, o_count); end
    end
    i_valid = 1'b0;
  endtask

  task automatic test_full_pop_push();
    drain();
    i_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin rand_entry(); i_valid = 1'b1; step(); end
    i_ready = 1'b1;
    rand_entry();
    step();
    n_checks += 2;
    if (o_count !== CW'(3))     begin n_errors++; $display("FAIL fullpp_first: got %0d expected 3", o_count); end
    if (o_result !== q[0].result) begin n_errors++; $display("FAIL fullpp_head1: got %0h expected %0h", o_result, q[0].result); end
    rand_entry();
    step();
    n_checks += 2;
    if (o_count !== CW'(3))     begin n_errors++; $display("FAIL fullpp_second: got %0d expected 3", o_count); end
    if (o_result !== q[0].result) begin n_errors++; $display("FAIL fullpp_head2: got %0h expected %0h", o_result, q[0].result); end
    i_valid = 1'b0;
  endtask

  task automatic test_pop_empty();
    drain();
    i_ready = 1'b1; i_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_checks += 3;
    if (o_count  !== '0)   begin n_errors++; $display("FAIL popempty_count: got %0d expected 0", o_count); end
    if (o_valid  !== 1'b0) begin n_errors++; $display("FAIL popempty_valid: got %0b expected 0", o_valid); end
    if (o_result !== '0)   begin n_errors++; $display("FAIL popempty_result: got %0h expected 0", o_result); end
    // Next push after the ignored pops must surface normally.
    i_ready = 1'b0; rand_entry(); i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_result !== q[0].result) begin n_errors++; $display("FAIL popempty_next: got %0h expected %0h", o_result, q[0].result); end
  endtask

  task automatic test_async_reset();
    logic [BITS-1:0] first;
    drain();
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_entry(); i_valid = 1'b1; step(); end
    i_valid = 1'b0;
    #3 i_rst_n = 1'b0;
    #1;
    model_reset();
    n_checks += 7;
    if (o_count  !== '0)   begin n_errors++; $display("FAIL arst_count: got %0d expected 0", o_count); end
    if (o_empty  !== 1'b1) begin n_errors++; $display("FAIL arst_empty: got %0b expected 1", o_empty); end
    if (o_valid  !== 1'b0) begin n_errors++; $display("FAIL arst_valid: got %0b expected 0", o_valid); end
    if (o_ready  !== 1'b1 || o_full !== 1'b0) begin n_errors++; $display("FAIL arst_ready_full: got %0b/%0b expected 1/0", o_ready, o_full); end
    if (o_result !== '0 || o_oper !== '0 || o_flags !== '0) begin n_errors++; $display("FAIL arst_head: got %0h/%0h/%0h expected 0/0/0", o_oper, o_result, o_flags); end
    if (o_drops  !== 8'd0) begin n_errors++; $display("FAIL arst_drops: got %0d expected 0", o_drops); end
    if (o_sticky !== 4'h0) begin n_errors++; $display("FAIL arst_sticky: got %0h expected 0", o_sticky); end
    #1 i_rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_empty !== 1'b1) begin n_errors++; $display("FAIL arst_release_empty: got %0b expected 1", o_empty); end
    // First edge after release accepts a push; nothing stale may follow it.
    rand_entry(); first = i_result; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    n_checks += 2;
    if (o_count  !== CW'(1)) begin n_errors++; $display("FAIL arst_first_count: got %0d expected 1", o_count); end
    if (o_result !== first)  begin n_errors++; $display("FAIL arst_first_result: got %0h expected %0h", o_result, first); end
    i_ready = 1'b1;
    step();
    n_checks++;
    if (o_empty !== 1'b1) begin n_errors++; $display("FAIL arst_no_stale: got %0b expected 1", o_empty); end
    i_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0]    e_oper;
    logic [BITS-1:0] e_result;
    logic [3:0]      e_flags;
    for (int i = 0; i < 400; i++) begin
      rand_entry();
      i_valid      = ($urandom_range(0, 3) != 0);
      i_ready      = ($urandom_range(0, 1) != 0);
      i_clr_sticky = ($urandom_range(0, 7) == 0);
      step();
      e_oper   = (q.size() > 0) ? q[0].oper   : '0;
      e_result = (q.size() > 0) ? q[0].result : '0;
      e_flags  = (q.size() > 0) ? q[0].flags  : '0;
      n_checks += 8;
      if (o_count  !== CW'(q.size()))        begin n_errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", i, o_count, q.size()); end
      if (o_full   !== (q.size() == DEPTH))  begin n_errors++; $display("FAIL rand_full@%0d: got %0b", i, o_full); end
      if (o_empty  !== (q.size() == 0))      begin n_errors++; $display("FAIL rand_empty@%0d: got %0b", i, o_empty); end
      if (o_valid  !== (q.size() != 0) || o_ready !== (q.size() != DEPTH)) begin n_errors++; $display("FAIL rand_handshake@%0d: got v%0b r%0b size %0d", i, o_valid, o_ready, q.size()); end
      if (o_oper !== e_oper || o_result !== e_result || o_flags !== e_flags) begin
        n_errors++;
        $display("FAIL rand_head@%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", i, o_oper, o_result, o_flags, e_oper, e_result, e_flags);
      end
      if (o_drops  !== 8'(m_drops))          begin n_errors++; $display("FAIL rand_drops@%0d: got %0d expected %0d", i, o_drops, m_drops); end
      if (o_sticky !== m_sticky)             begin n_errors++; $display("FAIL rand_sticky@%0d: got %04b expected %04b", i, o_sticky, m_sticky); end
      if (o_count  > CW'(DEPTH))             begin n_errors++; $display("FAIL rand_bound@%0d: got %0d expected <= %0d", i, o_count, DEPTH); end
    end
    i_valid = 1'b0; i_clr_sticky = 1'b0;
  endtask

  task automatic test_drop_saturate();
    drain();
    i_ready = 1'b0; i_valid = 1'b1;
    for (int i = 0; i < DEPTH + 260; i++) begin rand_entry(); step(); end
    i_valid = 1'b0;
    n_checks += 2;
    if (o_drops !== 8'd255)      begin n_errors++; $display("FAIL drops_saturate: got %0d expected 255", o_drops); end
    if (o_drops !== 8'(m_drops)) begin n_errors++; $display("FAIL drops_model: got %0d expected %0d", o_drops, m_drops); end
    drain();
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_sticky();
    test_single_push();
    test_fill_drop();
    test_back_to_back();
    test_full_pop_push();
    test_pop_empty();
    test_async_reset();
    test_random();
    test_drop_saturate();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
